pipelined_adder: RTL

//  Parametrised, pipelined ripple-carry adder; WIDTH-bit operands summed with carry-in over STAGES

---
 rtl/pipelined_adder_pkg.sv | 34 +++
 rtl/pipelined_adder_if.sv | 42 ++++
 rtl/pipelined_adder_adder_slice.sv | 44 ++++
 rtl/pipelined_adder.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_adder_pkg
//   Shared elaboration helpers for the pipelined ripple-carry adder.
//   - slice_width     : bits added per pipeline stage (WIDTH / STAGES)
//   - stage_idx_width : bits needed to number a stage (minimum 1)
//   - cfg_ok          : legal WIDTH/STAGES combination check used at elaboration
//   No ports (package).
// -----------------------------------------------------------------------------
package pipelined_adder_pkg;

   // Width of the operand slice handled by one stage.
   function automatic int slice_width(input int width, input int stages);
      if (stages > 0) begin
         return width / stages;
      end else begin
         return width;
      end
   endfunction

   // Index width for a stage counter; never zero so it can size a vector.
   function automatic int stage_idx_width(input int stages);
      if (stages > 1) begin
         return $clog2(stages);
      end else begin
         return 1;
      end
   endfunction

   // Stages must evenly divide the operand and lie in 1..WIDTH.
   function automatic bit cfg_ok(input int width, input int stages);
      return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// -----------------------------------------------------------------------------
// pipelined_adder_if
//   Operand/result handshake bundle for pipelined_adder.
//   Upstream  : i_valid, o_ready, i_A, i_B, i_Cin
//   Downstream: o_valid, i_ready, o_S, o_Cout, o_Ovf (o_Ovf only when
//               PIPE_ADDER_OVF_EN is defined)
//   Modports  : master = the side that supplies operands and consumes sums,
//               slave  = the adder.
// -----------------------------------------------------------------------------
interface pipelined_adder_if #(
   parameter int WIDTH = 16
);
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_A;
   logic [WIDTH-1:0] i_B;
   logic             i_Cin;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_S;
   logic             o_Cout;
`ifdef PIPE_ADDER_OVF_EN
   logic             o_Ovf;
`endif

   modport master (
      output i_valid, i_A, i_B, i_Cin, i_ready,
      input  o_ready, o_valid, o_S, o_Cout
`ifdef PIPE_ADDER_OVF_EN
      , input o_Ovf
`endif
   );

   modport slave (
      input  i_valid, i_A, i_B, i_Cin, i_ready,
      output o_ready, o_valid, o_S, o_Cout
`ifdef PIPE_ADDER_OVF_EN
      , output o_Ovf
`endif
   );

endinterface

// File: rtl/pipelined_adder_adder_slice.sv
// -----------------------------------------------------------------------------
// adder_slice
//   Purely combinational SW-bit ripple of full-adder bit cells
//   (S = a^b^c, Co = ab | (a^b)c).
//   Ports: a, b   SW-bit operand slices
//          cin    carry into bit 0 of the slice
//          sum    SW-bit sum slice
//          cout   carry out of the slice MSB
//          c_msb  carry into the slice MSB (only with PIPE_ADDER_OVF_EN)
// -----------------------------------------------------------------------------
module adder_slice #(
   parameter int SW = 4
) (
   input  logic [SW-1:0] a,
   input  logic [SW-1:0] b,
   input  logic          cin,
   output logic [SW-1:0] sum,
   output logic          cout
`ifdef PIPE_ADDER_OVF_EN
   ,
   output logic          c_msb
`endif
);

   // carry_s[i] is the carry into bit i; carry_s[SW] leaves the slice
   logic [SW:0] carry_s;

   // Bit-cell ripple from LSB to MSB
   always_comb begin
      carry_s    = {(SW+1){1'b0}};
      sum        = {SW{1'b0}};
      carry_s[0] = cin;
      for (int i = 0; i < SW; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry_s[i];
         carry_s[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & carry_s[i]);
      end
   end

   assign cout = carry_s[SW];
`ifdef PIPE_ADDER_OVF_EN
   assign c_msb = carry_s[SW-1];
`endif

endmodule

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//   WIDTH-bit ripple-carry adder with carry-in, split into STAGES register
//   stages of WIDTH/STAGES bits. Latency STAGES cycles, one beat per cycle,
//   valid/ready handshake with full backpressure (whole pipe moves or holds).
//   Ports: i_clk    clock, rising edge
//          i_rst_n  asynchronous active-low reset
//          bus      pipelined_adder_if.slave (i_valid/o_ready/i_A/i_B/i_Cin in,
//                   o_valid/i_ready/o_S/o_Cout[/o_Ovf] out)
//   Optional: define PIPE_ADDER_OVF_EN to add the registered signed-overflow
//   flag o_Ovf (carry into MSB xor carry out of MSB).
// -----------------------------------------------------------------------------
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   pipelined_adder_if.slave  bus
);

   localparam int SW = slice_width(WIDTH, STAGES);

   if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
      $error("pipelined_adder: STAGES must divide WIDTH and lie in 1..WIDTH");
   end

   // Element k feeds stage k; element k+1 is what stage k registered.
   // Operand skew words are shifted right as slices are consumed, so the
   // next slice to add always sits in the low SW bits.
   logic                          advance_s;
   logic [STAGES:0]               valid_pipe_s;
   logic [STAGES:0]               carry_pipe_s;
   logic [STAGES:0][WIDTH-1:0]    sum_pipe_s;
   logic [STAGES-1:0][WIDTH-1:0]  a_pipe_s;
   logic [STAGES-1:0][WIDTH-1:0]  b_pipe_s;
`ifdef PIPE_ADDER_OVF_EN
   logic                          ovf_s;
`endif

   // The pipe only holds when a result sits at the output and is refused
   assign advance_s    = ~valid_pipe_s[STAGES] | bus.i_ready;
   assign bus.o_ready  = advance_s;

   assign valid_pipe_s[0] = bus.i_valid;
   assign carry_pipe_s[0] = bus.i_Cin;
   assign sum_pipe_s[0]   = {WIDTH{1'b0}};
   assign a_pipe_s[0]     = bus.i_A;
   assign b_pipe_s[0]     = bus.i_B;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [SW-1:0]    slice_sum_s;
      logic             slice_co_s;
      logic [WIDTH-1:0] nxt_sum_s;
      logic             valid_r;
      logic             carry_r;
      logic [WIDTH-1:0] sum_r;
`ifdef PIPE_ADDER_OVF_EN
      logic             slice_cmsb_s;
`endif

      adder_slice #(.SW(SW)) u_slice (
         .a     (a_pipe_s[k][SW-1:0]),
         .b     (b_pipe_s[k][SW-1:0]),
         .cin   (carry_pipe_s[k]),
         .sum   (slice_sum_s),
         .cout  (slice_co_s)
`ifdef PIPE_ADDER_OVF_EN
         ,
         .c_msb (slice_cmsb_s)
`endif
      );

      // Deskew: finished low slices shift down, the new slice enters at the top
      always_comb begin
         nxt_sum_s                = sum_pipe_s[k] >> SW;
         nxt_sum_s[WIDTH-1 -: SW] = slice_sum_s;
      end

      // Stage valid follows the pipe; data only loads for a real beat
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            valid_r <= 1'b0;
            carry_r <= 1'b0;
            sum_r   <= {WIDTH{1'b0}};
         end else if (advance_s) begin
            valid_r <= valid_pipe_s[k];
            if (valid_pipe_s[k]) begin
               carry_r <= slice_co_s;
               sum_r   <= nxt_sum_s;
            end
         end
      end

      assign valid_pipe_s[k+1] = valid_r;
      assign carry_pipe_s[k+1] = carry_r;
      assign sum_pipe_s[k+1]   = sum_r;

      if (k < STAGES-1) begin : g_skew
         logic [WIDTH-1:0] a_r;
         logic [WIDTH-1:0] b_r;

         // Operand slices not yet added travel alongside the partial sum
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               a_r <= {WIDTH{1'b0}};
               b_r <= {WIDTH{1'b0}};
            end else if (advance_s && valid_pipe_s[k]) begin
               a_r <= a_pipe_s[k] >> SW;
               b_r <= b_pipe_s[k] >> SW;
            end
         end

         assign a_pipe_s[k+1] = a_r;
         assign b_pipe_s[k+1] = b_r;
`ifdef PIPE_ADDER_OVF_EN
         // Only the final slice holds the operand MSB
         logic unused_cmsb_s;
         assign unused_cmsb_s = slice_cmsb_s;
`endif
      end else begin : g_last
         // Upper skew bits reaching the last stage are always zero
         logic unused_skew_s;
         assign unused_skew_s = ^{a_pipe_s[k], b_pipe_s[k]};
`ifdef PIPE_ADDER_OVF_EN
         logic ovf_r;

         // Overflow flag is registered with the beat it describes
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               ovf_r <= 1'b0;
            end else if (advance_s && valid_pipe_s[k]) begin
               ovf_r <= slice_cmsb_s ^ slice_co_s;
            end
         end

         assign ovf_s = ovf_r;
`endif
      end
   end

   assign bus.o_valid = valid_pipe_s[STAGES];
   assign bus.o_S     = sum_pipe_s[STAGES];
   assign bus.o_Cout  = carry_pipe_s[STAGES];
`ifdef PIPE_ADDER_OVF_EN
   assign bus.o_Ovf   = ovf_s;
`endif

endmodule
